// File: rtl/multicycle_dp_pkg.sv
// Shared constants, FSM state enum, ALU-op enum and instruction decode helpers
// for the multicycle datapath.
package multicycle_dp_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_J, CLS_ILLEGAL
  } instr_cls_t;

  function automatic instr_cls_t decode_cls(input logic [5:0] op, input logic [5:0] fn);
    instr_cls_t cls;
    cls = CLS_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT)
          cls = CLS_RTYPE;
      end
      OP_ADDI: cls = CLS_ADDI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_J:    cls = CLS_J;
      default: cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  // Only R-type selects a non-add operation; addi/lw/sw all add base and immediate.
  function automatic alu_op_t decode_alu(input logic [5:0] op, input logic [5:0] fn);
    alu_op_t a;
    a = ALU_ADD;
    if (op == OP_RTYPE) begin
      case (fn)
        FN_SUB:  a = ALU_SUB;
        FN_AND:  a = ALU_AND;
        FN_OR:   a = ALU_OR;
        FN_SLT:  a = ALU_SLT;
        default: a = ALU_ADD;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: two asynchronous reads, one synchronous write, register 0
// hard-wired to zero.
module mc_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] i_raddr_a,
  input  logic [$clog2(NREGS)-1:0] i_raddr_b,
  input  logic                     i_we,
  input  logic [$clog2(NREGS)-1:0] i_waddr,
  input  logic [XLEN-1:0]          i_wdata,
  output logic [XLEN-1:0]          o_rdata_a,
  output logic [XLEN-1:0]          o_rdata_b
);

  logic [XLEN-1:0] r_regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-style datapath: FETCH/DECODE/EXEC/MEM/WB FSM over req/ack memories.
// Define MULTICYCLE_DP_JUMP_EN to enable the j instruction (otherwise opcode 02 is illegal).
module multicycle_datapath
  import multicycle_dp_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic [XLEN-1:0] result,
  output logic            retire,
  output logic            illegal,
  output state_t          o_dbg_state
);

  localparam int AW = $clog2(NREGS);

  state_t          r_state, w_state_nxt;
  instr_cls_t      r_cls, w_cls_dec;
  alu_op_t         r_alu_op;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_pc, r_a, r_b, r_imm, r_bt, r_alu, r_result;
  logic [XLEN-1:0] w_pc_nxt, w_pc4, w_jump_pc, w_imm, w_bt;
  logic [XLEN-1:0] w_rdata_a, w_rdata_b, w_alu_b, w_alu_out;
  logic [AW-1:0]   w_waddr;
  logic            w_rf_we;

  assign w_pc4 = r_pc + XLEN'(4);
  assign w_imm = {{(XLEN-16){r_ir[15]}}, r_ir[15:0]};
  assign w_bt  = w_pc4 + (w_imm << 2);

  always_comb begin
    w_cls_dec = decode_cls(r_ir[31:26], r_ir[5:0]);
`ifdef MULTICYCLE_DP_JUMP_EN
    w_jump_pc = {w_pc4[XLEN-1:28], r_ir[25:0], 2'b00};
`else
    w_jump_pc = w_pc4;
    if (w_cls_dec == CLS_J) w_cls_dec = CLS_ILLEGAL;
`endif
  end

  // R-type takes rd and the rt operand; immediates write rt and use IMM as operand B.
  assign w_alu_b = (r_cls == CLS_RTYPE) ? r_b : r_imm;
  assign w_waddr = (r_cls == CLS_RTYPE) ? r_ir[11 +: AW] : r_ir[16 +: AW];

  always_comb begin
    w_alu_out = r_a + w_alu_b;
    case (r_alu_op)
      ALU_SUB: w_alu_out = r_a - w_alu_b;
      ALU_AND: w_alu_out = r_a & w_alu_b;
      ALU_OR:  w_alu_out = r_a | w_alu_b;
      ALU_SLT: w_alu_out = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(w_alu_b))};
      default: w_alu_out = r_a + w_alu_b;
    endcase
  end

  mc_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .i_raddr_a (r_ir[21 +: AW]),
    .i_raddr_b (r_ir[16 +: AW]),
    .i_we      (w_rf_we),
    .i_waddr   (w_waddr),
    .i_wdata   (r_alu),
    .o_rdata_a (w_rdata_a),
    .o_rdata_b (w_rdata_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= PC_RESET;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_rf_we     = 1'b0;
    retire      = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      FETCH: if (imem_ack) w_state_nxt = DECODE;
      DECODE: begin
        if (w_cls_dec == CLS_ILLEGAL) begin
          illegal     = 1'b1;
          w_pc_nxt    = w_pc4;
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        case (r_cls)
          CLS_BEQ: begin
            retire      = 1'b1;
            w_pc_nxt    = (r_a == r_b) ? r_bt : w_pc4;
            w_state_nxt = FETCH;
          end
          CLS_J: begin
            retire      = 1'b1;
            w_pc_nxt    = w_jump_pc;
            w_state_nxt = FETCH;
          end
          CLS_LW, CLS_SW: w_state_nxt = MEM;
          default:        w_state_nxt = WB;
        endcase
      end
      MEM: begin
        if (dmem_ack) begin
          if (r_cls == CLS_SW) begin
            retire      = 1'b1;
            w_pc_nxt    = w_pc4;
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = WB;
          end
        end
      end
      WB: begin
        w_rf_we     = 1'b1;
        retire      = 1'b1;
        w_pc_nxt    = w_pc4;
        w_state_nxt = FETCH;
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_bt     <= '0;
      r_alu    <= '0;
      r_result <= '0;
      r_cls    <= CLS_RTYPE;
      r_alu_op <= ALU_ADD;
    end else begin
      case (r_state)
        FETCH: if (imem_ack) r_ir <= imem_rdata;
        DECODE: begin
          r_a      <= w_rdata_a;
          r_b      <= w_rdata_b;
          r_imm    <= w_imm;
          r_bt     <= w_bt;
          r_cls    <= w_cls_dec;
          r_alu_op <= decode_alu(r_ir[31:26], r_ir[5:0]);
        end
        EXEC: r_alu <= w_alu_out;
        MEM:  if (dmem_ack && (r_cls == CLS_LW)) r_alu <= dmem_rdata;
        WB:   r_result <= r_alu;
        default: ;
      endcase
    end
  end

  // imem_req is gated by rst so nothing is requested while reset is held.
  assign imem_req    = (r_state == FETCH) && !rst;
  assign imem_addr   = r_pc;
  assign dmem_req    = (r_state == MEM);
  assign dmem_we     = (r_state == MEM) && (r_cls == CLS_SW);
  assign dmem_addr   = r_alu;
  assign dmem_wdata  = r_b;
  assign result      = r_result;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed self-checking bench for multicycle_datapath with wait-state memory models.
// Honours MULTICYCLE_DP_JUMP_EN for the expected behaviour of opcode 02.
module tb_multicycle_datapath;
  import multicycle_dp_pkg::*;

  logic        clk, rst;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, illegal;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, result;
  state_t      dbg_state;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int          imem_wait, dmem_wait, i_cnt, d_cnt, st_cnt;
  logic [31:0] st_addr, st_data;
  logic        dack_force;
  int          n_checks, n_errors;

  multicycle_datapath dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .result(result), .retire(retire), .illegal(illegal), .o_dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory models: ack after the programmed number of wait cycles; last store is forwarded to loads.
  assign imem_ack   = imem_req && (i_cnt >= imem_wait);
  assign imem_rdata = imem[imem_addr[9:2]];
  assign dmem_ack   = (dmem_req && (d_cnt >= dmem_wait)) || dack_force;
  assign dmem_rdata = (st_cnt != 0 && dmem_addr == st_addr) ? st_data : dmem[dmem_addr[9:2]];

  always @(posedge clk) begin
    i_cnt <= (imem_req && !imem_ack) ? i_cnt + 1 : 0;
    d_cnt <= (dmem_req && !dmem_ack) ? d_cnt + 1 : 0;
    if (dmem_req && dmem_ack && dmem_we) begin
      st_addr <= dmem_addr;
      st_data <= dmem_wdata;
      st_cnt  <= st_cnt + 1;
    end
  end

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_wait = 0; dmem_wait = 0; dack_force = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Runs one instruction from its first cycle; returns its cycle count and which pulse ended it.
  task automatic step(output int cyc, output logic ret, output logic ill);
    cyc = 0; ret = 1'b0; ill = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc++;
      ret = retire;
      ill = illegal;
      if (ret || ill) break;
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    clear_mem();
    imem[0] = itype(OP_ADDI, 0, 1, 16'd5);
    rst = 1'b1; dack_force = 1'b0; imem_wait = 0; dmem_wait = 0;
    @(negedge clk); #1;
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL rst_imem_req got %b exp 0", imem_req); end
    n_checks++; if (dmem_req !== 1'b0) begin n_errors++; $display("FAIL rst_dmem_req got %b exp 0", dmem_req); end
    n_checks++; if (dmem_we !== 1'b0) begin n_errors++; $display("FAIL rst_dmem_we got %b exp 0", dmem_we); end
    n_checks++; if (retire !== 1'b0 || illegal !== 1'b0) begin n_errors++; $display("FAIL rst_pulses got %b%b exp 00", retire, illegal); end
    n_checks++; if (result !== 32'h0) begin n_errors++; $display("FAIL rst_result got %h exp 0", result); end
    n_checks++; if (dbg_state !== FETCH) begin n_errors++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
    @(negedge clk);
    rst = 1'b0; #1;
    n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL rel_imem_req got %b exp 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL rel_imem_addr got %h exp 0", imem_addr); end
  endtask

  task automatic test_addi();
    int cyc; logic ret, ill;
    clear_mem();
    imem[0] = itype(OP_ADDI, 0, 1, 16'd5);
    do_reset();
    step(cyc, ret, ill);
    n_checks++; if (cyc !== 4 || ret !== 1'b1) begin n_errors++; $display("FAIL addi_latency got %0d/%b exp 4/1", cyc, ret); end
    n_checks++; if (result !== 32'd5) begin n_errors++; $display("FAIL addi_result got %h exp 5", result); end
    n_checks++; if (imem_addr !== 32'h4) begin n_errors++; $display("FAIL addi_next_pc got %h exp 4", imem_addr); end
  endtask

  task automatic test_alu();
    logic [31:0] prog [12];
    logic [31:0] expv [12];
    int          expc [12];
    int cyc; logic ret, ill;
    prog[0]  = itype(OP_LW, 0, 1, 16'h0040);   expv[0]  = 32'h7FFFFFFF; expc[0]  = 5;
    prog[1]  = itype(OP_ADDI, 0, 2, 16'd1);    expv[1]  = 32'h00000001; expc[1]  = 4;
    prog[2]  = rtype(1, 2, 3, FN_ADD);         expv[2]  = 32'h80000000; expc[2]  = 4;
    prog[3]  = rtype(3, 1, 4, FN_SLT);         expv[3]  = 32'h00000001; expc[3]  = 4;
    prog[4]  = rtype(1, 3, 7, FN_SLT);         expv[4]  = 32'h00000000; expc[4]  = 4;
    prog[5]  = rtype(3, 2, 5, FN_SUB);         expv[5]  = 32'h7FFFFFFF; expc[5]  = 4;
    prog[6]  = rtype(3, 2, 6, FN_OR);          expv[6]  = 32'h80000001; expc[6]  = 4;
    prog[7]  = rtype(6, 3, 8, FN_AND);         expv[7]  = 32'h80000000; expc[7]  = 4;
    prog[8]  = rtype(0, 2, 9, FN_SUB);         expv[8]  = 32'hFFFFFFFF; expc[8]  = 4;
    prog[9]  = itype(OP_ADDI, 3, 10, 16'hFFFF); expv[9] = 32'h7FFFFFFF; expc[9]  = 4;
    prog[10] = rtype(2, 2, 0, FN_ADD);         expv[10] = 32'h00000002; expc[10] = 4;
    prog[11] = rtype(0, 2, 11, FN_ADD);        expv[11] = 32'h00000001; expc[11] = 4;
    clear_mem();
    for (int i = 0; i < 12; i++) imem[i] = prog[i];
    dmem[16] = 32'h7FFFFFFF;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(cyc, ret, ill);
      n_checks++;
      if (cyc !== expc[i] || ret !== 1'b1 || ill !== 1'b0) begin
        n_errors++; $display("FAIL alu_timing[%0d] got %0d/%b/%b exp %0d/1/0", i, cyc, ret, ill, expc[i]);
      end
      n_checks++;
      if (result !== expv[i]) begin n_errors++; $display("FAIL alu_result[%0d] got %h exp %h", i, result, expv[i]); end
    end
  endtask

  task automatic test_mem_wait();
    int cyc; logic ret, ill; int st0;
    clear_mem();
    imem[0] = itype(OP_ADDI, 0, 1, 16'd5);
    imem[1] = itype(OP_SW, 0, 1, 16'd8);
    imem[2] = itype(OP_LW, 0, 5, 16'd8);
    imem[3] = itype(OP_ADDI, 0, 6, 16'hFFFD);
    imem[4] = itype(OP_SW, 1, 6, 16'h000C);
    do_reset();
    dmem_wait = 3;
    step(cyc, ret, ill);
    st0 = st_cnt;
    step(cyc, ret, ill);
    n_checks++; if (cyc !== 7 || ret !== 1'b1) begin n_errors++; $display("FAIL sw_wait_latency got %0d/%b exp 7/1", cyc, ret); end
    n_checks++; if (st_cnt !== st0 + 1 || st_addr !== 32'h8 || st_data !== 32'h5) begin
      n_errors++; $display("FAIL sw_store got n=%0d a=%h d=%h exp n=%0d a=8 d=5", st_cnt, st_addr, st_data, st0 + 1);
    end
    n_checks++; if (result !== 32'd5) begin n_errors++; $display("FAIL sw_result_kept got %h exp 5", result); end
    step(cyc, ret, ill);
    n_checks++; if (cyc !== 8 || ret !== 1'b1) begin n_errors++; $display("FAIL lw_wait_latency got %0d/%b exp 8/1", cyc, ret); end
    n_checks++; if (result !== 32'd5) begin n_errors++; $display("FAIL lw_result got %h exp 5", result); end
    imem_wait = 2; dmem_wait = 0;
    step(cyc, ret, ill);
    n_checks++; if (cyc !== 6) begin n_errors++; $display("FAIL imem_wait_latency got %0d exp 6", cyc); end
    n_checks++; if (result !== 32'hFFFFFFFD) begin n_errors++; $display("FAIL addi_neg got %h exp fffffffd", result); end
    imem_wait = 0;
    step(cyc, ret, ill);
    n_checks++; if (cyc !== 4 || st_addr !== 32'h11 || st_data !== 32'hFFFFFFFD) begin
      n_errors++; $display("FAIL sw_base_offset got c=%0d a=%h d=%h exp c=4 a=11 d=fffffffd", cyc, st_addr, st_data);
    end
  endtask

  task automatic test_branch();
    int cyc; logic ret, ill;
    clear_mem();
    imem[0] = itype(OP_ADDI, 0, 1, 16'd5);
    imem[1] = itype(OP_ADDI, 0, 2, 16'd7);
    imem[2] = itype(OP_ADDI, 0, 3, 16'd3);
    imem[3] = itype(OP_BEQ, 1, 2, 16'd7);
    imem[4] = itype(OP_BEQ, 1, 1, 16'hFFFF);
    do_reset();
    repeat (3) step(cyc, ret, ill);
    step(cyc, ret, ill);
    n_checks++; if (cyc !== 3 || ret !== 1'b1 || imem_addr !== 32'h10) begin
      n_errors++; $display("FAIL beq_not_taken_c got c=%0d r=%b pc=%h exp c=3 r=1 pc=10", cyc, ret, imem_addr);
    end
    step(cyc, ret, ill);
    n_checks++; if (cyc !== 3 || imem_addr !== 32'h10) begin
      n_errors++; $display("FAIL beq_self_loop got c=%0d pc=%h exp c=3 pc=10", cyc, imem_addr);
    end
    n_checks++; if (result !== 32'd3) begin n_errors++; $display("FAIL beq_result_kept got %h exp 3", result); end
    imem[4] = itype(OP_BEQ, 1, 2, 16'hFFFF);
    imem[5] = itype(OP_BEQ, 2, 2, 16'd3);
    imem[9] = itype(OP_ADDI, 0, 4, 16'd9);
    do_reset();
    repeat (4) step(cyc, ret, ill);
    step(cyc, ret, ill);
    n_checks++; if (imem_addr !== 32'h14) begin n_errors++; $display("FAIL beq_ne_pc got %h exp 14", imem_addr); end
    step(cyc, ret, ill);
    n_checks++; if (imem_addr !== 32'h24) begin n_errors++; $display("FAIL beq_fwd_pc got %h exp 24", imem_addr); end
    step(cyc, ret, ill);
    n_checks++; if (result !== 32'd9) begin n_errors++; $display("FAIL beq_target_exec got %h exp 9", result); end
  endtask

  task automatic test_illegal();
    int cyc; logic ret, ill;
    clear_mem();
    imem[0]  = itype(OP_ADDI, 0, 1, 16'd5);
    imem[1]  = 32'hFC000000;
    imem[2]  = rtype(1, 1, 7, 6'h3F);
    imem[3]  = {OP_J, 26'h10};
    imem[4]  = rtype(1, 0, 6, FN_ADD);
    imem[16] = rtype(1, 0, 6, FN_ADD);
    do_reset();
    step(cyc, ret, ill);
    step(cyc, ret, ill);
    n_checks++; if (cyc !== 2 || ill !== 1'b1 || ret !== 1'b0) begin
      n_errors++; $display("FAIL illegal_op got c=%0d i=%b r=%b exp c=2 i=1 r=0", cyc, ill, ret);
    end
    n_checks++; if (imem_addr !== 32'h8 || result !== 32'd5) begin
      n_errors++; $display("FAIL illegal_op_state got pc=%h res=%h exp pc=8 res=5", imem_addr, result);
    end
    step(cyc, ret, ill);
    n_checks++; if (cyc !== 2 || ill !== 1'b1 || ret !== 1'b0 || imem_addr !== 32'hC) begin
      n_errors++; $display("FAIL illegal_funct got c=%0d i=%b r=%b pc=%h exp c=2 i=1 r=0 pc=c", cyc, ill, ret, imem_addr);
    end
    step(cyc, ret, ill);
`ifdef MULTICYCLE_DP_JUMP_EN
    n_checks++; if (cyc !== 3 || ret !== 1'b1 || ill !== 1'b0 || imem_addr !== 32'h40) begin
      n_errors++; $display("FAIL jump got c=%0d r=%b i=%b pc=%h exp c=3 r=1 i=0 pc=40", cyc, ret, ill, imem_addr);
    end
`else
    n_checks++; if (cyc !== 2 || ret !== 1'b0 || ill !== 1'b1 || imem_addr !== 32'h10) begin
      n_errors++; $display("FAIL jump_disabled got c=%0d r=%b i=%b pc=%h exp c=2 r=0 i=1 pc=10", cyc, ret, ill, imem_addr);
    end
`endif
    step(cyc, ret, ill);
    n_checks++; if (result !== 32'd5 || cyc !== 4) begin
      n_errors++; $display("FAIL regs_after_illegal got res=%h c=%0d exp res=5 c=4", result, cyc);
    end
  endtask

  task automatic test_reset_mid_mem();
    int cyc; logic ret, ill; int st0; logic seen;
    clear_mem();
    imem[0] = itype(OP_ADDI, 0, 1, 16'd5);
    imem[1] = itype(OP_SW, 0, 1, 16'd8);
    do_reset();
    dmem_wait = 5;
    step(cyc, ret, ill);
    st0 = st_cnt;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dmem_req) begin seen = 1'b1; break; end
      @(negedge clk); #1;
    end
    n_checks++; if (seen !== 1'b1) begin n_errors++; $display("FAIL mid_mem_reach got %b exp 1", seen); end
    rst = 1'b1; dack_force = 1'b1;
    #1;
    n_checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin
      n_errors++; $display("FAIL mid_rst_dmem got req=%b we=%b exp 0 0", dmem_req, dmem_we);
    end
    n_checks++; if (dbg_state !== FETCH || result !== 32'h0) begin
      n_errors++; $display("FAIL mid_rst_state got st=%0d res=%h exp 0 0", dbg_state, result);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_errors++; $display("FAIL post_rst_fetch got req=%b pc=%h exp 1 0", imem_req, imem_addr);
    end
    step(cyc, ret, ill);
    dack_force = 1'b0;
    n_checks++; if (cyc !== 4 || result !== 32'd5 || st_cnt !== st0) begin
      n_errors++; $display("FAIL post_rst_exec got c=%0d res=%h st=%0d exp c=4 res=5 st=%0d", cyc, result, st_cnt, st0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; dack_force = 1'b0; imem_wait = 0; dmem_wait = 0;
    test_reset();
    test_addi();
    test_alu();
    test_mem_wait();
    test_branch();
    test_illegal();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 Parameter XLEN, default 32, data/address width; the block SHALL support 32 and 64.
REQ-002 Parameter NREGS, default 32, register count; the block SHALL support powers of two from 8 to 32, with register address width clog2(NREGS).
REQ-003 Parameter PC_RESET, default 0, PC value loaded on reset.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 imem_req  out  1 / imem_addr  out  XLEN / imem_rdata  in  32 / imem_ack  in  1; these SHALL form the instruction fetch handshake.
REQ-007 dmem_req  out  1 / dmem_we  out  1 / dmem_addr  out  XLEN / dmem_wdata  out  XLEN / dmem_rdata  in  XLEN / dmem_ack  in  1; these SHALL form the data handshake.
REQ-008 result  out  XLEN  SHALL carry the last value written to the register file.
REQ-009 retire  out  1  SHALL pulse one cycle per completed instruction.
REQ-010 illegal  out  1  SHALL pulse one cycle per undecodable opcode or funct.

Function
REQ-011 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB.
REQ-012 FETCH: the block SHALL hold imem_req=1 and imem_addr=PC until imem_ack, then latch IR=imem_rdata and go to DECODE.
REQ-013 DECODE: the block SHALL latch A=rf[rs], B=rf[rt], IMM=sign-extend(IR[15:0]) to XLEN, and BT=PC+4+(IMM<<2).
REQ-014 Supported instructions SHALL be: R-type add/sub/and/or/slt (funct 20/22/24/25/2A hex), addi (08), lw (23), sw (2B), beq (04), and j (02, see REQ-026).
REQ-015 EXEC, R-type/addi: ALU result SHALL be latched, then WB.
REQ-016 EXEC, lw/sw: addr=A+IMM SHALL be latched, then MEM.
REQ-017 EXEC, beq: PC SHALL be set to (A==B)?BT:PC+4, retire SHALL pulse, then FETCH.
REQ-018 MEM: the block SHALL hold dmem_req=1, dmem_addr=addr, dmem_we=(sw), dmem_wdata=B until dmem_ack.
REQ-019 On dmem_ack, sw SHALL set PC=PC+4, pulse retire and go to FETCH; lw SHALL latch dmem_rdata and go to WB.
REQ-020 WB: the block SHALL write rd (R-type) or rt (addi/lw), update result, set PC=PC+4, pulse retire and go to FETCH.
REQ-021 With zero-wait acks, latency SHALL be 4 cycles for R-type/addi/sw, 5 for lw and 3 for beq/j; each wait cycle SHALL add exactly one cycle.
REQ-022 Register 0 SHALL read as zero; writes to it SHALL be discarded, and result SHALL still update.
REQ-023 Arithmetic SHALL wrap modulo 2^XLEN; slt SHALL be signed; PC SHALL wrap at 2^XLEN.
REQ-024 For rs/rt/rd >= NREGS, only the low clog2(NREGS) bits SHALL be used.
REQ-025 On an illegal opcode or funct in DECODE, the block SHALL pulse illegal, leave registers unchanged, set PC=PC+4 and go to FETCH without pulsing retire.

Configuration
REQ-026 With MULTICYCLE_DP_JUMP_EN defined, j SHALL set PC={PC+4[XLEN-1:28], IR[25:0], 2'b00} in EXEC and pulse retire.
REQ-027 Without MULTICYCLE_DP_JUMP_EN, opcode 02 SHALL be illegal per REQ-025.

Reset
REQ-028 Asserting rst SHALL immediately set state=FETCH, PC=PC_RESET, all registers, result, IR, A, B and latches to 0, and imem_req/dmem_req/dmem_we/retire/illegal to 0.
REQ-029 Reset during a pending memory handshake SHALL abandon it, and an ack arriving during or after reset SHALL be ignored.
REQ-030 After rst deasserts, the first fetch SHALL issue at the next rising edge.

Structure
REQ-031 Package multicycle_dp_pkg SHALL hold opcode/funct constants, the state enum and the ALU-op enum.
REQ-032 Sub-module mc_regfile (parameters XLEN, NREGS; two asynchronous reads, one synchronous write, r0 zero) SHALL implement the register file.

Verification
REQ-033 addi r1,r0,5 with zero-wait acks -> rf[1]=5, result=5, retire 4 cycles after reset release.
REQ-034 add r3,r1,r2 with r1=0x7FFFFFFF, r2=1 and XLEN=32 -> r3=0x80000000; slt r4,r3,r1 -> r4=1.
REQ-035 sw r1,8(r0) then lw r5,8(r0), with dmem_ack delayed 3 cycles each -> dmem_addr=8, dmem_wdata=5, r5=5, lw taking 8 cycles.
REQ-036 beq r1,r1,-1 at PC=0x10 -> next imem_addr=0x10; beq with r1!=r2 -> next imem_addr=0x14.
REQ-037 Opcode 0x3F -> illegal pulses, retire does not, registers unchanged, next imem_addr=PC+4; opcode 02 behaves per REQ-026/REQ-027 under each macro setting.
REQ-038 rst asserted while dmem_req=1 -> dmem_req drops the same cycle, and the first fetch after release uses imem_addr=PC_RESET.
